// File: rtl/draw_pkg.sv
// draw_pkg: shared constants and types for the rectangle drawing path.
//   - screen geometry and field widths used by the arbiter and game FSMs
//   - 3-bit RGB colour constants for vga_adapter
//   - arbiter state encoding
package draw_pkg;

  localparam int XSCREEN = 160;
  localparam int YSCREEN = 120;
  localparam int XW      = 8;
  localparam int YW      = 7;
  localparam int DW      = 4;
  localparam int CW      = 3;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin priority select.
//   req     : request vector
//   pointer : index that currently has highest priority
//   gnt     : one-hot grant of the first requester at or after pointer,
//             searching cyclically; all zero when nothing is requesting
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  gnt
);

  logic          found;
  int            pos;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(pointer) + k;
      if (pos >= N) pos = pos - N;
      idx = pos[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rect_draw_arbiter.sv
// rect_draw_arbiter: shares the vga_adapter pixel port among N_REQ requesters,
// each asking for a filled rectangle. One requester is served at a time in
// round-robin order; its rectangle is scanned row-major, one pixel per clock.
//   CLOCK_50, resetn            : clock, async active-low reset
//   req                         : per-requester level request
//   req_x/_y/_w/_h/_colour      : packed per-requester rectangle fields
//   grant                       : one-hot, held for the whole service
//   done                        : one-cycle pulse when a rectangle completes
//   busy                        : high whenever not idle
//   vga_x, vga_y, vga_colour    : pixel to the adapter
//   plot                        : pixel write strobe (off-screen pixels masked)
//
// state | meaning
// IDLE  | waiting for any request; arbitrates and latches fields
// DRAW  | scanning the latched rectangle, one pixel per cycle
// DONE  | pulse done for the granted requester, advance rr pointer
module rect_draw_arbiter #(
  parameter int N_REQ   = 3,
  parameter int XW      = draw_pkg::XW,
  parameter int YW      = draw_pkg::YW,
  parameter int DW      = draw_pkg::DW,
  parameter int CW      = draw_pkg::CW,
  parameter int XSCREEN = draw_pkg::XSCREEN,
  parameter int YSCREEN = draw_pkg::YSCREEN
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*XW-1:0] req_x,
  input  logic [N_REQ*YW-1:0] req_y,
  input  logic [N_REQ*DW-1:0] req_w,
  input  logic [N_REQ*DW-1:0] req_h,
  input  logic [N_REQ*CW-1:0] req_colour,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    done,
  output logic                busy,
  output logic [XW-1:0]       vga_x,
  output logic [YW-1:0]       vga_y,
  output logic [CW-1:0]       vga_colour,
  output logic                plot
);

  import draw_pkg::*;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state, state_nxt;

  logic [N_REQ-1:0] gnt_sel, grant_q;
  logic [PW-1:0]    rr_ptr, sel_idx, gidx_q;
  logic [XW-1:0]    sel_x, x_q;
  logic [YW-1:0]    sel_y, y_q;
  logic [DW-1:0]    sel_w, sel_h, w_q, h_q;
  logic [CW-1:0]    sel_colour, colour_q;
  logic [DW-1:0]    xc, yc, w_last, h_last;
  logic [XW:0]      sum_x;
  logic [YW:0]      sum_y;
  logic             any_req, row_end, last_px, drawing;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr (
    .req     (req),
    .pointer (rr_ptr),
    .gnt     (gnt_sel)
  );

  // Field mux driven by the one-hot arbiter result.
  always_comb begin
    sel_idx    = '0;
    sel_x      = '0;
    sel_y      = '0;
    sel_w      = '0;
    sel_h      = '0;
    sel_colour = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_sel[i]) begin
        sel_idx    = PW'(i);
        sel_x      = req_x[i*XW +: XW];
        sel_y      = req_y[i*YW +: YW];
        sel_w      = req_w[i*DW +: DW];
        sel_h      = req_h[i*DW +: DW];
        sel_colour = req_colour[i*CW +: CW];
      end
    end
  end

  assign any_req = |req;
  assign w_last  = w_q - 1'b1;
  assign h_last  = h_q - 1'b1;
  assign row_end = (xc == w_last);
  assign last_px = row_end && (yc == h_last);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = (sel_w == '0 || sel_h == '0) ? DONE : DRAW;
      DRAW: if (last_px) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      colour_q <= '0;
      xc       <= '0;
      yc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_q  <= gnt_sel;
            gidx_q   <= sel_idx;
            x_q      <= sel_x;
            y_q      <= sel_y;
            w_q      <= sel_w;
            h_q      <= sel_h;
            colour_q <= sel_colour;
            xc       <= '0;
            yc       <= '0;
          end
        end
        DRAW: begin
          if (row_end) begin
            xc <= '0;
            yc <= yc + 1'b1;
          end else begin
            xc <= xc + 1'b1;
          end
        end
        DONE: begin
          grant_q <= '0;
          rr_ptr  <= (gidx_q == PW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sums carry one extra bit so pixels past the screen edge are detected
  // rather than wrapping back onto visible coordinates.
  assign drawing    = (state == DRAW);
  assign sum_x      = {1'b0, x_q} + (XW+1)'(xc);
  assign sum_y      = {1'b0, y_q} + (YW+1)'(yc);
  assign plot       = drawing && (sum_x < (XW+1)'(XSCREEN)) && (sum_y < (YW+1)'(YSCREEN));
  assign vga_x      = drawing ? sum_x[XW-1:0] : '0;
  assign vga_y      = drawing ? sum_y[YW-1:0] : '0;
  assign vga_colour = drawing ? colour_q : '0;
  assign done       = (state == DONE) ? grant_q : '0;
  assign busy       = (state != IDLE);
  assign grant      = grant_q;

endmodule

// File: tb/tb_rect_draw_arbiter.sv
module tb_rect_draw_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [11:0] req_w;
  logic [11:0] req_h;
  logic [8:0]  req_colour;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot;

  rect_draw_arbiter dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;

  logic [7:0] rx [3];
  logic [6:0] ry [3];
  logic [3:0] rw [3];
  logic [3:0] rh [3];
  logic [2:0] rc [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      req_x[i*8 +: 8]      = rx[i];
      req_y[i*7 +: 7]      = ry[i];
      req_w[i*4 +: 4]      = rw[i];
      req_h[i*4 +: 4]      = rh[i];
      req_colour[i*3 +: 3] = rc[i];
    end
  endtask

  function automatic int pick(input logic [2:0] m);
    for (int k = 0; k < 3; k++) begin
      if (m[(model_ptr + k) % 3]) return (model_ptr + k) % 3;
    end
    return 0;
  endfunction

  // Serve whichever requester the round-robin rule selects, checking every
  // cycle from grant to the return to idle. mut_at>=0 changes that
  // requester's colour and drops its req after that pixel index.
  task automatic serve(input string tag, input bit drop, input int mut_at);
    int         g, idx, ex, ey;
    logic [7:0] lx;
    logic [6:0] ly;
    logic [3:0] lw, lh;
    logic [2:0] lc, oh;
    logic       pl;
    g  = pick(req);
    oh = 3'b001 << g;
    lx = rx[g]; ly = ry[g]; lw = rw[g]; lh = rh[g]; lc = rc[g];
    tick();
    chk({tag, " grant"}, {busy, grant}, {1'b1, oh});
    idx = 0;
    for (int yy = 0; yy < int'(lh); yy++) begin
      for (int xx = 0; xx < int'(lw); xx++) begin
        ex = int'(lx) + xx;
        ey = int'(ly) + yy;
        pl = (ex < 160) && (ey < 120);
        chk($sformatf("%s px%0d", tag, idx),
            {plot, vga_x, vga_y, vga_colour, grant},
            {pl, 8'(ex), 7'(ey), lc, oh});
        if (idx == mut_at) begin
          rc[g]  = ~rc[g];
          req[g] = 1'b0;
          drive();
        end
        idx++;
        tick();
      end
    end
    chk({tag, " done"}, {done, grant, plot, busy}, {oh, oh, 1'b0, 1'b1});
    if (drop) req[g] = 1'b0;
    tick();
    chk({tag, " idle"}, {busy, done, grant, plot}, 32'd0);
    model_ptr = (g + 1) % 3;
  endtask

  task automatic do_reset();
    #2 resetn = 1'b0;
    #1 chk("reset", {grant, done, busy, plot}, 32'd0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    tick();
    model_ptr = 0;
  endtask

  initial begin
    resetn = 1'b0;
    req    = 3'b000;
    for (int i = 0; i < 3; i++) begin
      rx[i] = '0; ry[i] = '0; rw[i] = '0; rh[i] = '0; rc[i] = '0;
    end
    drive();
    #12;
    chk("por outputs", {grant, done, busy, plot, vga_x, vga_y, vga_colour}, 32'd0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    tick();
    chk("por idle", {busy, grant}, 32'd0);

    // Single 2x2 request
    rx[0] = 8'd10; ry[0] = 7'd20; rw[0] = 4'd2; rh[0] = 4'd2; rc[0] = 3'b010;
    req = 3'b001; drive();
    serve("single", 1'b1, -1);

    // Simultaneous requests after reset: 0 then 1
    do_reset();
    rx[0] = 8'd5;  ry[0] = 7'd5; rw[0] = 4'd3; rh[0] = 4'd1; rc[0] = 3'b100;
    rx[1] = 8'd40; ry[1] = 7'd7; rw[1] = 4'd2; rh[1] = 4'd3; rc[1] = 3'b001;
    req = 3'b011; drive();
    serve("simul a", 1'b1, -1);
    serve("simul b", 1'b1, -1);

    // Continuous contention with 1x1 rectangles
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rx[i] = 8'(20 * i + 1); ry[i] = 7'(3 * i + 2); rw[i] = 4'd1; rh[i] = 4'd1; rc[i] = 3'(i + 1);
    end
    req = 3'b111; drive();
    for (int n = 0; n < 4; n++) serve($sformatf("contend%0d", n), 1'b0, -1);
    req = 3'b000;
    tick();
    chk("contend release", {busy, grant}, 32'd0);

    // Zero width
    rx[1] = 8'd50; ry[1] = 7'd50; rw[1] = 4'd0; rh[1] = 4'd5; rc[1] = 3'b111;
    req = 3'b010; drive();
    serve("zero w", 1'b1, -1);

    // Clipping at the bottom-right corner
    rx[2] = 8'd158; ry[2] = 7'd118; rw[2] = 4'd4; rh[2] = 4'd4; rc[2] = 3'b100;
    req = 3'b100; drive();
    serve("clip", 1'b1, -1);

    // Field change and req drop during DRAW
    rx[0] = 8'd20; ry[0] = 7'd30; rw[0] = 4'd3; rh[0] = 4'd2; rc[0] = 3'b111;
    req = 3'b001; drive();
    serve("fieldchg", 1'b1, 2);

    // Reset in the middle of a 10x10 draw
    rx[1] = 8'd30; ry[1] = 7'd30; rw[1] = 4'd10; rh[1] = 4'd10; rc[1] = 3'b100;
    req = 3'b010; drive();
    tick();
    chk("midrst granted", {busy, grant}, {1'b1, 3'b010});
    repeat (5) tick();
    #2 resetn = 1'b0;
    #1 chk("midrst async", {grant, plot, busy, done, vga_x, vga_y, vga_colour}, 32'd0);
    req = 3'b000;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    tick();
    model_ptr = 0;
    chk("midrst idle", {busy, grant}, 32'd0);
    rx[2] = 8'd60; ry[2] = 7'd10; rw[2] = 4'd2; rh[2] = 4'd1; rc[2] = 3'b001;
    req = 3'b100; drive();
    serve("after rst", 1'b1, -1);
    rx[0] = 8'd1; ry[0] = 7'd1; rw[0] = 4'd1; rh[0] = 4'd2; rc[0] = 3'b010;
    rx[1] = 8'd2; ry[1] = 7'd2; rw[1] = 4'd2; rh[1] = 4'd1; rc[1] = 3'b011;
    req = 3'b011; drive();
    serve("wrap a", 1'b1, -1);
    serve("wrap b", 1'b1, -1);

    // Random request sets, each held until its done
    for (int r = 0; r < 20; r++) begin
      logic [2:0] m;
      m = 3'($urandom_range(1, 7));
      for (int i = 0; i < 3; i++) begin
        if (m[i]) begin
          rx[i] = 8'($urandom_range(0, 175));
          ry[i] = 7'($urandom_range(0, 127));
          rw[i] = 4'($urandom_range(0, 5));
          rh[i] = 4'($urandom_range(0, 5));
          rc[i] = 3'($urandom_range(0, 7));
        end
      end
      req = m; drive();
      for (int s = 0; s < 3; s++) begin
        if (req != 3'b000) serve($sformatf("rand%0d.%0d", r, s), 1'b1, -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rect_draw_arbiter.md
Name: rect_draw_arbiter

Overview:
- Shares the single vga_adapter pixel-write port (x, y, colour, plot) among N drawing requesters: snake-body draw, tail erase, apple draw, etc.
- Each requester asks for a filled rectangle. The block grants one requester at a time in round-robin order and sequences the pixel scan, one pixel per clock.
- Replaces the per-object XC/YC counter pairs and the hand-chained draw states in the top-level FSM.
- Sits between the game FSMs and vga_adapter.

Parameters:
- N_REQ, 3, number of requesters
- XW, 8, x-coordinate width
- YW, 7, y-coordinate width
- DW, 4, rectangle width/height field width (max 15)
- CW, 3, colour width
- XSCREEN, 160, visible columns
- YSCREEN, 120, visible rows

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester draw request, level
- req_x  in  N_REQ*XW  packed rectangle origin x; requester i uses slice i
- req_y  in  N_REQ*YW  packed origin y
- req_w  in  N_REQ*DW  packed width in pixels
- req_h  in  N_REQ*DW  packed height in pixels
- req_colour  in  N_REQ*CW  packed fill colour
- grant  out  N_REQ  one-hot; high for the whole service of requester i
- done  out  N_REQ  one-cycle pulse when requester i's rectangle is complete
- busy  out  1  high whenever state != IDLE
- vga_x  out  XW  pixel x to adapter
- vga_y  out  YW  pixel y to adapter
- vga_colour  out  CW  pixel colour to adapter
- plot  out  1  pixel write strobe to adapter

Behaviour:
- Reset, asynchronous, any state including mid-draw:
  - state=IDLE
  - grant=0, done=0, busy=0, plot=0
  - vga_x/vga_y/vga_colour=0
  - rr pointer=0
  - xc=yc=0
- States:
  - IDLE: waits for any req.
  - DRAW: one pixel per cycle.
  - DONE: one cycle.
- IDLE with any req=1 at a clock edge:
  - Select the first requesting index at or after the rr pointer, cyclically.
  - Register grant one-hot and latch that requester's x, y, w, h and colour.
  - Clear xc and yc.
  - Go to DRAW, or go straight to DONE if w==0 or h==0.
- DRAW:
  - Pixel = (X+xc, Y+yc), colour = latched colour.
  - xc increments each cycle. When xc==W-1: xc clears and yc increments. When also yc==H-1: go to DONE.
  - Scan order is row-major.
  - Exactly W*H DRAW cycles.
- Clipping:
  - Sums are formed in XW+1 and YW+1 bits.
  - plot=1 only if X+xc < XSCREEN and Y+yc < YSCREEN; otherwise plot=0 but the cycle is still consumed.
  - vga_x/vga_y carry the truncated sums.
- DONE:
  - done[i]=1 for the granted i; grant is still asserted.
  - rr pointer <= i+1, wrapping at N_REQ.
  - Next state is IDLE.
- Outputs: plot, vga_* and done decode combinationally from registered state/counters/latches. No extra pipeline, because the adapter registers its inputs.
- Latency:
  - req rises (sampled at edge 0) → first plot in cycle 1 → done in cycle 1+W*H → IDLE in the next cycle.
  - The earliest re-grant is at the IDLE edge, so there is a 2-cycle gap between rectangles.
- Handshake:
  - Requester holds req and its fields stable until it sees done, then drops req.
  - If req is still high in IDLE, it is treated as a new request (re-arbitrated, not ignored).
- Request changes during service:
  - Dropping req or changing fields mid-service has no effect; the latched values are used and done still pulses.
  - Requests arriving during DRAW/DONE wait; no request is lost while held.
- Fairness: with all requesters continuously asserted, grants cycle 0,1,2,0,… Starvation is bounded by N_REQ-1 services.

Decomposition:
- Package draw_pkg:
  - XSCREEN, YSCREEN, XW, YW, DW, CW
  - Colour constants: BLACK=3'b000, RED=3'b100, GREEN=3'b010, BLUE=3'b001, WHITE=3'b111
  - Arbiter state encoding: IDLE=2'd0, DRAW=2'd1, DONE=2'd2
- One sub-module, rr_arbiter:
  - Inputs: req[N_REQ], pointer.
  - Output: one-hot gnt.
  - Purely combinational priority rotate; reused later for the score/text overlay.

Test Plan:
- Single request:
  - Stimulus: req[0]=1, origin (10,20), 2x2, colour 3'b010.
  - Response: plot at (10,20), (11,20), (10,21), (11,21) on cycles 1–4; done[0] on cycle 5; busy low on cycle 6; grant=3'b001 throughout.
- Simultaneous requests:
  - Stimulus: req=3'b011 after reset.
  - Response: requester 0 served first, then requester 1; done[0] precedes done[1]; no overlapping plot streams.
- Continuous contention:
  - Stimulus: req=3'b111 held high, each 1x1.
  - Response: grant sequence 001, 010, 100, 001; each done exactly once per rotation.
- Zero-size and clipping:
  - Stimulus A: w=0, h=5.
  - Response A: no plot; done one cycle after grant.
  - Stimulus B: 4x4 at (158,118).
  - Response B: 16 DRAW cycles; plot=1 only for (158,118), (159,118), (158,119), (159,119).
- Reset mid-operation:
  - Stimulus: resetn low during DRAW of a 10x10 rectangle.
  - Response: grant, plot, busy and done go to 0 immediately (asynchronously); after release, a fresh req[2] is granted first, since the rr pointer is 0 and requester 2 is the only one requesting.
- Field change mid-service:
  - Stimulus: change req_colour[0] and drop req[0] during DRAW.
  - Response: all pixels use the latched colour; done[0] still pulses.
